// File: rtl/seg7_scan_driver_if.sv
// Load handshake between a value source and seg7_scan_driver.
// The source holds value/value_valid until it sees value_ready at a clock edge.
interface seg7_scan_driver_if #(
    parameter int IN_WIDTH = 6
);
    logic [IN_WIDTH-1:0] value;
    logic                value_valid;
    logic                value_ready;

    modport master (output value, output value_valid, input value_ready);
    modport slave  (input value, input value_valid, output value_ready);
endinterface

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD 7-segment driver: sequential shift-add-3 conversion feeding a
// time-multiplexed common-anode display with zero blanking, overflow and blink.
module seg7_scan_driver #(
    parameter int IN_WIDTH   = 6,
    parameter int NUM_DIGITS = 2,
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_DIV  = 50,
    parameter int BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_scan_driver_if.slave     load_if,
    input  logic                  blink,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  overflow
);

    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int CNT_W   = $clog2(IN_WIDTH + 1);
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int CMP_W   = (IN_WIDTH > 32) ? IN_WIDTH : 32;
    localparam int MAX_VAL = 10 ** NUM_DIGITS - 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;

    state_t              state_q;
    logic                ready_q;
    logic [IN_WIDTH-1:0] bin_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [CNT_W-1:0]    shift_cnt_q;
    logic                ovf_pend_q;
    logic [BCD_W-1:0]    disp_q;
    logic                overflow_q;
    logic [SCAN_W-1:0]   scan_cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [BLK_W-1:0]    blink_cnt_q;
    logic                phase_on_q;
    logic [6:0]          seg_q;
    logic [NUM_DIGITS-1:0] an_q;

    logic [BCD_W-1:0]      bcd_adj;
    logic [BCD_W-1:0]      bcd_d;
    logic [6:0]            seg_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            digit_pat [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  scan_wrap;
    logic                  round_wrap;

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0001100;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // Per-digit add-3 correction, pattern lookup and leading-zero detection.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                               : bcd_q[4*gi +: 4];
        assign digit_pat[gi] = seg_code(disp_q[4*gi +: 4]);
        if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign lz_blank[gi] = (disp_q[BCD_W-1:4*gi] == '0);
        end
    end

    // The adjusted accumulator's top bit falls off the end; overflow covers it.
    assign bcd_d      = BCD_W'({bcd_adj, bin_q[IN_WIDTH-1]});
    assign scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign round_wrap = scan_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // blink is used directly so that clearing it restores the display at once.
    always_comb begin
        seg_d = digit_pat[idx_q];
        if (overflow_q) begin
            seg_d = 7'b1111110;
        end else if ((BLANK_LZ != 0) && lz_blank[idx_q]) begin
            seg_d = 7'b1111111;
        end
        if (blink && !phase_on_q) begin
            seg_d = 7'b1111111;
        end
        an_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            bin_q       <= '0;
            bcd_q       <= '0;
            shift_cnt_q <= '0;
            ovf_pend_q  <= 1'b0;
            disp_q      <= '0;
            overflow_q  <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
            seg_q       <= 7'b1111111;
            an_q        <= '1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_if.value_valid) begin
                        bin_q       <= load_if.value;
                        bcd_q       <= '0;
                        shift_cnt_q <= CNT_W'(IN_WIDTH);
                        ovf_pend_q  <= (CMP_W'(load_if.value) > CMP_W'(MAX_VAL));
                        ready_q     <= 1'b0;
                        state_q     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_q       <= bcd_d;
                    bin_q       <= bin_q << 1;
                    shift_cnt_q <= shift_cnt_q - CNT_W'(1);
                    if (shift_cnt_q == CNT_W'(1)) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    disp_q     <= bcd_q;
                    overflow_q <= ovf_pend_q;
                    ready_q    <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase

            if (scan_wrap) begin
                scan_cnt_q <= '0;
                idx_q      <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
            end

            if (!blink) begin
                blink_cnt_q <= '0;
                phase_on_q  <= 1'b1;
            end else if (round_wrap) begin
                if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                    blink_cnt_q <= '0;
                    phase_on_q  <= ~phase_on_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BLK_W'(1);
                end
            end

            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign load_if.value_ready = ready_q;
    assign seg                 = seg_q;
    assign an                  = an_q;
    assign overflow            = overflow_q;

endmodule
